string_input_writer: RTL

- Console-input side of the string syscalls: the write counterpart of the print_string reader in instruction memory.
- On a read_string syscall it accepts characters one per handshake and packs them two per 16-bit word: first character in the high byte, second in the low byte.
- Words are written into instruction/data memory starting at the word address taken from the accumulator.
- The string is always null-terminated in the layout print_string expects, so a string written by this block prints back unchanged.

---
 rtl/string_input_writer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/string_input_writer.sv
// Packs console input characters two per 16-bit word and writes them,
// null-terminated, into memory starting at the word address given by the accumulator.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   read_string, read_data_acc_buf   syscall strobe and base word address
//   char_valid, char_data            input character stream
//   char_ready                       character accepted when valid && ready
//   mem_we, mem_addr, mem_wdata      registered memory write port
//   busy, done                       operation in progress / completion pulse
//   overflow, char_count             truncation flag and stored length
module string_input_writer #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_string,
    input  logic [7:0]        read_data_acc_buf,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        char_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_TERM_HI,
        S_TERM_LO,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                char_ready_q, char_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                accept;
    logic                is_term;
    logic [7:0]          count_inc;
    logic                hit_max;

    assign accept    = char_valid && char_ready_q;
    assign is_term   = (char_data == 8'h00) || (char_data == 8'h0A);
    assign count_inc = count_q + 8'd1;
    assign hit_max   = (count_inc == 8'(MAX_LEN));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (read_string) begin
                    addr_d  = ADDR_W'(read_data_acc_buf);
                    count_d = 8'd0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    if (is_term) begin
                        state_d = S_TERM_HI;
                    end else begin
                        hi_d    = char_data;
                        count_d = count_inc;
                        if (hit_max) begin
                            // Truncated with a pending high byte: the
                            // terminator shares its word.
                            ovf_d   = 1'b1;
                            state_d = S_TERM_LO;
                        end else begin
                            state_d = S_LO;
                        end
                    end
                end
            end
            S_LO: begin
                if (accept) begin
                    if (is_term) begin
                        state_d = S_TERM_LO;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {hi_q, char_data};
                        mem_addr_d  = addr_q;
                        addr_d      = addr_q + ADDR_W'(1);
                        count_d     = count_inc;
                        if (hit_max) begin
                            ovf_d   = 1'b1;
                            state_d = S_TERM_HI;
                        end else begin
                            state_d = S_HI;
                        end
                    end
                end
            end
            S_TERM_HI: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = 16'h0000;
                mem_addr_d  = addr_q;
                addr_d      = addr_q + ADDR_W'(1);
                state_d     = S_FIN;
            end
            S_TERM_LO: begin
                mem_we_d    = 1'b1;
                mem_wdata_d = {hi_q, 8'h00};
                mem_addr_d  = addr_q;
                addr_d      = addr_q + ADDR_W'(1);
                state_d     = S_FIN;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        char_ready_d = (state_d == S_HI) || (state_d == S_LO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            hi_q         <= 8'd0;
            count_q      <= 8'd0;
            ovf_q        <= 1'b0;
            char_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 16'h0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hi_q         <= hi_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            char_ready_q <= char_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign char_ready = char_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign char_count = count_q;

endmodule
